// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Holds the FSM state, the requester identity and the latched command record.
package mem_arb_pkg;

  localparam int unsigned ADDR_MAX_DEFAULT = 1020;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_e;

  // Command captured at grant time and replayed in ACCESS/RESP.
  typedef struct packed {
    req_e        who;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Misaligned or out-of-range addresses complete with an error, never touching memory.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned max_addr);
    return (addr[1:0] != 2'b00) || (addr > 32'(max_addr));
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not granted last. Bit 0 is fetch, bit 1 is data.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_e       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == REQ_D) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one shared
// memory; one transaction in flight, grant -> strobe -> response over three cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_MAX = ADDR_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic        if_err,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,

  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] memData
);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  req_e        last_q, last_d;

  logic [1:0]  rr_gnt;
  logic        grant;
  req_e        winner;
  logic [31:0] win_addr;

  mem_arb_rr2 u_rr2 (
    .req_i  ({d_req, if_req}),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  // Requests are only looked at while idle; anything else is ignored.
  assign grant    = (state_q == IDLE) && (rr_gnt != 2'b00);
  assign winner   = rr_gnt[1] ? REQ_D : REQ_IF;
  assign win_addr = (winner == REQ_D) ? d_addr : if_addr;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command and round-robin pointer capture.
  always_comb begin
    cmd_d  = cmd_q;
    last_d = last_q;
    if (grant) begin
      cmd_d.who  = winner;
      cmd_d.we   = (winner == REQ_D) ? d_we : 1'b0;
      cmd_d.err  = addr_bad(win_addr, ADDR_MAX);
      cmd_d.addr = win_addr;
      if (winner == REQ_D) begin
        cmd_d.wdata = d_wdata;
      end
      last_d = winner;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q  <= '{who: REQ_IF, we: 1'b0, err: 1'b0, addr: 32'h0, wdata: 32'h0};
      last_q <= REQ_D;
    end else begin
      cmd_q  <= cmd_d;
      last_q <= last_d;
    end
  end

  // Output decode.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    if_err    = 1'b0;
    if_rdata  = 32'h0;
    d_rvalid  = 1'b0;
    d_err     = 1'b0;
    d_rdata   = 32'h0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Grants are combinational from req, so mask them while reset is held.
        if (resetn) begin
          if_gnt = rr_gnt[0];
          d_gnt  = rr_gnt[1];
        end
      end
      ACCESS: begin
        if (!cmd_q.err) begin
          memRead  = !cmd_q.we;
          memWrite = cmd_q.we;
        end
      end
      RESP: begin
        if (cmd_q.who == REQ_IF) begin
          if_rvalid = 1'b1;
          if_err    = cmd_q.err;
          if_rdata  = cmd_q.err ? 32'h0 : memData;
        end else begin
          d_rvalid = 1'b1;
          d_err    = cmd_q.err;
          d_rdata  = (cmd_q.err || cmd_q.we) ? 32'h0 : memData;
        end
      end
      default: begin
      end
    endcase
  end

  assign address   = cmd_q.addr;
  assign writeData = cmd_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, predictive arbitration model with
// expectation queues, and an independent monitor that drains them.
module tb_mem_arbiter;

  localparam int unsigned AddrMax = 1020;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        memRead, memWrite;
  logic [31:0] address, writeData;
  logic [31:0] memData = 32'h0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_MAX(AddrMax)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_err    (if_err),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .address   (address),
    .writeData (writeData),
    .memData   (memData)
  );

  typedef struct {
    bit          port;
    int          due;
    bit          err;
    bit          we;
    logic [31:0] data;
    logic [7:0]  idx;
    logic [31:0] wdata;
  } resp_t;

  typedef struct {
    int          due;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } strb_t;

  resp_t       rq[$];
  strb_t       sq[$];
  logic [31:0] mem_dev [256];
  logic [31:0] mem_ref [256];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          model_last_d = 1'b1;
  int          last_gnt = -10;
  int          act_gnt_port[$];
  int          act_gnt_cyc[$];
  logic [31:0] last_if_rdata = 32'h0;
  logic [31:0] last_d_rdata = 32'h0;
  logic        last_d_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared memory: read data registered one cycle after the memRead edge.
  always @(posedge clk) begin
    if (memRead) memData <= mem_dev[address[9:2]];
    if (memWrite) mem_dev[address[9:2]] <= writeData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    tests++;
    fails++;
    $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
  endtask

  // Reference model: predicts grants from the arbitration rules and queues the
  // strobe and response each grant must produce.
  initial begin
    logic        exp_if, exp_d, err, we;
    logic [31:0] a;
    bit          port;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        rq.delete();
        sq.delete();
        model_last_d = 1'b1;
        last_gnt = -10;
        check("rst_gnt", {30'h0, if_gnt, d_gnt}, 32'h0);
        check("rst_strobe", {30'h0, memRead, memWrite}, 32'h0);
        check("rst_rvalid_err", {28'h0, if_rvalid, d_rvalid, if_err, d_err}, 32'h0);
        check("rst_rdata", if_rdata | d_rdata, 32'h0);
        check("rst_addr_wdata", address | writeData, 32'h0);
        continue;
      end
      exp_if = 1'b0;
      exp_d = 1'b0;
      if (cyc >= last_gnt + 3) begin
        if (if_req && d_req) begin
          if (model_last_d) exp_if = 1'b1;
          else exp_d = 1'b1;
        end else if (if_req) exp_if = 1'b1;
        else if (d_req) exp_d = 1'b1;
      end
      check("if_gnt", {31'h0, if_gnt}, {31'h0, exp_if});
      check("d_gnt", {31'h0, d_gnt}, {31'h0, exp_d});
      if (exp_if || exp_d) begin
        port = exp_d;
        a = port ? d_addr : if_addr;
        we = port ? d_we : 1'b0;
        err = (a[1:0] != 2'b00) || (a > AddrMax);
        rq.push_back('{port: port, due: cyc + 2, err: err, we: we,
                       data: (err || we) ? 32'h0 : mem_ref[a[9:2]], idx: a[9:2], wdata: d_wdata});
        if (!err) sq.push_back('{due: cyc + 1, we: we, addr: a, wdata: d_wdata});
        last_gnt = cyc;
        model_last_d = port;
      end
    end
  end

  // Monitor: consumes expectations whenever the DUT strobes memory or responds.
  initial begin
    strb_t       s;
    resp_t       r;
    logic [31:0] rd;
    logic        er;
    forever begin
      @(negedge clk);
      if (!resetn) continue;
      if (if_gnt || d_gnt) begin
        act_gnt_port.push_back(d_gnt ? 1 : 0);
        act_gnt_cyc.push_back(cyc);
      end
      if (memRead || memWrite) begin
        if (sq.size() == 0) begin
          fail_now("strobe_unexpected", "memory strobe with no transaction pending");
        end else begin
          s = sq.pop_front();
          check("strobe_cycle", cyc, s.due);
          check("strobe_kind", {30'h0, memRead, memWrite}, s.we ? 32'h1 : 32'h2);
          check("strobe_addr", address, s.addr);
          if (s.we) check("strobe_wdata", writeData, s.wdata);
        end
      end
      if (sq.size() > 0 && sq[0].due < cyc) begin
        fail_now("strobe_missing", "expected memory strobe never appeared");
        void'(sq.pop_front());
      end
      if (if_rvalid || d_rvalid) begin
        check("rvalid_both", {31'h0, if_rvalid & d_rvalid}, 32'h0);
        if (rq.size() == 0) begin
          fail_now("rvalid_unexpected", "response with no transaction pending");
        end else begin
          r = rq.pop_front();
          rd = r.port ? d_rdata : if_rdata;
          er = r.port ? d_err : if_err;
          check("resp_port", {31'h0, d_rvalid}, {31'h0, r.port});
          check("resp_cycle", cyc, r.due);
          check("resp_err", {31'h0, er}, {31'h0, r.err});
          check("resp_rdata", rd, r.data);
          check("resp_other_quiet", r.port ? (if_rdata | {31'h0, if_err}) :
                                             (d_rdata | {31'h0, d_err}), 32'h0);
          if (r.port) begin
            last_d_rdata = d_rdata;
            last_d_err = d_err;
          end else begin
            last_if_rdata = if_rdata;
          end
          if (r.we && !r.err) mem_ref[r.idx] = r.wdata;
        end
      end else begin
        check("idle_quiet", if_rdata | d_rdata | {30'h0, if_err, d_err}, 32'h0);
      end
      if (rq.size() > 0 && rq[0].due < cyc) begin
        fail_now("rvalid_missing", "expected response never appeared");
        void'(rq.pop_front());
      end
    end
  end

  // Drivers are entered just after a rising edge and return just after one.
  task automatic drive_if(input logic [31:0] a);
    bit got = 1'b0;
    if_req = 1'b1;
    if_addr = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_gnt) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("if_gnt_timeout", "fetch request never granted");
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic drive_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit got = 1'b0;
    d_req = 1'b1;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (d_gnt) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("d_gnt_timeout", "data request never granted");
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (rq.size() == 0 && sq.size() == 0) break;
      @(posedge clk);
    end
    #1;
    if (rq.size() != 0 || sq.size() != 0) fail_now("drain_timeout", "transactions left pending");
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic gap();
    int g = $urandom_range(0, 3);
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      1:       a = 32'h0000_0400;
      2:       a = 32'(AddrMax);
      3:       a = 32'hFFFF_FFFC;
      default: a = 32'(4 * $urandom_range(0, 15));
    endcase
    return a;
  endfunction

  initial begin
    #400000;
    fail_now("watchdog", "simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_dev[i] = 32'h1000_0000 + 32'(i);
      mem_ref[i] = 32'h1000_0000 + 32'(i);
    end
    mem_dev[0] = 32'h0000_2083;
    mem_ref[0] = 32'h0000_2083;

    // Fetch held through reset: grant must stay masked, then win on the first cycle.
    if_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    drive_if(32'h0);
    drain();
    check("fetch0_rdata", last_if_rdata, 32'h0000_2083);

    drive_d(1'b1, 32'h100, 32'hDEAD_BEEF);
    drive_d(1'b0, 32'h100, 32'h0);
    drain();
    check("store_load_rdata", last_d_rdata, 32'hDEAD_BEEF);

    drive_d(1'b0, 32'h102, 32'h0);
    drain();
    check("misaligned_err", {31'h0, last_d_err}, 32'h1);
    drive_d(1'b0, 32'h400, 32'h0);
    drain();
    check("range_err", {31'h0, last_d_err}, 32'h1);
    drive_d(1'b0, 32'(AddrMax), 32'h0);
    drain();
    check("addr_max_ok", {31'h0, last_d_err}, 32'h0);

    // Both ports requesting from reset release: strict alternation, three cycles apart.
    resetn = 1'b0;
    if_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    act_gnt_port.delete();
    act_gnt_cyc.delete();
    resetn = 1'b1;
    fork
      for (int k = 0; k < 4; k++) drive_if(32'(8 * k));
      for (int k = 0; k < 4; k++) drive_d(1'b0, 32'(8 * k + 4), 32'h0);
    join
    drain();
    check("rr_grant_count", act_gnt_port.size(), 8);
    for (int k = 0; k < act_gnt_port.size(); k++) begin
      check("rr_order", act_gnt_port[k], k % 2);
      if (k > 0) check("rr_spacing", act_gnt_cyc[k] - act_gnt_cyc[k-1], 3);
    end

    // Reset during the ACCESS cycle of a store aborts it.
    drive_d(1'b1, 32'h200, 32'hCAFE_F00D);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("abort_strobe_drop", {30'h0, memRead, memWrite}, 32'h0);
    check("abort_no_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive_d(1'b0, 32'h200, 32'h0);
    drain();
    check("abort_store_dropped", last_d_rdata, 32'h1000_0080);

    fork
      for (int k = 0; k < 60; k++) begin
        gap();
        drive_if(rand_addr());
      end
      for (int k = 0; k < 60; k++) begin
        gap();
        drive_d(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
